// File: rtl/ps2_nes_keymap_if.sv
// ps2_nes_keymap_if
//   Bundles the PS/2 decoder make/break flags (levels, one pair per key)
//   and the NES button outputs of the keymap.
//   master : decoder/consumer side - drives the flags, reads the buttons
//   slave  : keymap side           - reads the flags, drives the buttons
//   Flags  : W/S/A/D/F/E/T/R/Q _make / _break, 1 bit each
//   buttons: {R,L,DN,UP,STRT,SEL,B,A} bits 7..0, 1 = pressed
//   changed, turbo_on, timeout: 1 bit each
interface ps2_nes_keymap_if;
    logic       W_make, W_break;
    logic       S_make, S_break;
    logic       A_make, A_break;
    logic       D_make, D_break;
    logic       F_make, F_break;
    logic       E_make, E_break;
    logic       T_make, T_break;
    logic       R_make, R_break;
    logic       Q_make, Q_break;
    logic [7:0] buttons;
    logic       changed;
    logic       turbo_on;
    logic       timeout;

    modport master (
        output W_make, W_break, S_make, S_break, A_make, A_break,
               D_make, D_break, F_make, F_break, E_make, E_break,
               T_make, T_break, R_make, R_break, Q_make, Q_break,
        input  buttons, changed, turbo_on, timeout
    );

    modport slave (
        input  W_make, W_break, S_make, S_break, A_make, A_break,
               D_make, D_break, F_make, F_break, E_make, E_break,
               T_make, T_break, R_make, R_break, Q_make, Q_break,
        output buttons, changed, turbo_on, timeout
    );
endinterface

// File: rtl/ps2_nes_keymap.sv
// ps2_nes_keymap
//   Turns PS/2 decoder make/break level flags into a held NES button byte.
//   Adds Q-key turbo on A/B, SOCD neutralising of opposing directions and
//   a stuck-key timeout that drops held keys after a long idle period.
// Ports
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : ps2_nes_keymap_if.slave (flags in; buttons/changed/turbo_on/timeout out)
// Parameters
//   TURBO_HALF : cycles per turbo half-period (>= 2)
//   TIMEOUT    : idle cycles without any key edge before held keys drop (>= 2)
module ps2_nes_keymap #(
    parameter int TURBO_HALF = 1_666_666,
    parameter int TIMEOUT    = 250_000_000
) (
    input logic               clk,
    input logic               reset,
    ps2_nes_keymap_if.slave   bus
);
    localparam int TW = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TURBO_LAST = TW'(TURBO_HALF - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

    logic [7:0]    make_vec, break_vec;
    logic [7:0]    make_prev, break_prev;
    logic [7:0]    make_edge, break_edge;
    logic          q_make_prev, q_break_prev;
    logic          q_make_edge, q_break_edge;
    logic          armed;
    logic          any_edge;
    logic          fire;
    logic          turbo_run;

    logic [7:0]    held, held_next;
    logic [7:0]    buttons_q, buttons_next;
    logic          changed_q, timeout_q, turbo_q, phase;
    logic [TW-1:0] turbo_cnt;
    logic [IW-1:0] idle_cnt;

    // Bit order matches the NES button byte.
    assign make_vec  = {bus.D_make,  bus.A_make,  bus.S_make,  bus.W_make,
                        bus.R_make,  bus.T_make,  bus.E_make,  bus.F_make};
    assign break_vec = {bus.D_break, bus.A_break, bus.S_break, bus.W_break,
                        bus.R_break, bus.T_break, bus.E_break, bus.F_break};

    // 'armed' masks the first cycle after reset so flags that were already
    // high during reset load into the prev registers without acting.
    assign make_edge    = armed ? (make_vec  & ~make_prev)  : 8'h00;
    assign break_edge   = armed ? (break_vec & ~break_prev) : 8'h00;
    assign q_make_edge  = armed & bus.Q_make  & ~q_make_prev;
    assign q_break_edge = armed & bus.Q_break & ~q_break_prev;

    assign any_edge  = (|make_edge) | (|break_edge) | q_make_edge | q_break_edge;
    assign fire      = !any_edge && (idle_cnt == IDLE_LAST) && (held != 8'h00);
    assign turbo_run = turbo_q && (held[0] || held[1]);

    always_comb begin
        held_next = held;
        if (fire) begin
            held_next = 8'h00;
        end else begin
            // Break applied after make so it wins on a same-key collision.
            held_next = (held | make_edge) & ~break_edge;
        end
    end

    always_comb begin
        buttons_next = held;
        if (held[4] && held[5]) begin
            buttons_next[4] = 1'b0;
            buttons_next[5] = 1'b0;
        end
        if (held[6] && held[7]) begin
            buttons_next[6] = 1'b0;
            buttons_next[7] = 1'b0;
        end
        // Phase sits at 1 whenever turbo is idle, so this is transparent then.
        buttons_next[0] = held[0] & phase;
        buttons_next[1] = held[1] & phase;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            make_prev    <= 8'h00;
            break_prev   <= 8'h00;
            q_make_prev  <= 1'b0;
            q_break_prev <= 1'b0;
            armed        <= 1'b0;
            held         <= 8'h00;
            buttons_q    <= 8'h00;
            changed_q    <= 1'b0;
            timeout_q    <= 1'b0;
            turbo_q      <= 1'b0;
            phase        <= 1'b1;
            turbo_cnt    <= '0;
            idle_cnt     <= '0;
        end else begin
            make_prev    <= make_vec;
            break_prev   <= break_vec;
            q_make_prev  <= bus.Q_make;
            q_break_prev <= bus.Q_break;
            armed        <= 1'b1;
            held         <= held_next;
            buttons_q    <= buttons_next;
            changed_q    <= (buttons_next != buttons_q);
            timeout_q    <= fire;

            if (q_make_edge) begin
                turbo_q <= ~turbo_q;
            end

            if (turbo_run) begin
                if (turbo_cnt == TURBO_LAST) begin
                    turbo_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    turbo_cnt <= turbo_cnt + TW'(1);
                end
            end else begin
                turbo_cnt <= '0;
                phase     <= 1'b1;
            end

            if (any_edge || fire) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LAST) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

    assign bus.buttons  = buttons_q;
    assign bus.changed  = changed_q;
    assign bus.turbo_on = turbo_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_ps2_nes_keymap.sv
module tb_ps2_nes_keymap;
    localparam int KF = 0, KE = 1, KT = 2, KR = 3, KW = 4, KS = 5, KA = 6, KD = 7, KQ = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ps2_nes_keymap_if bus ();

    ps2_nes_keymap #(
        .TURBO_HALF (4),
        .TIMEOUT    (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_flag(input int key, input bit brk, input logic val);
        case (key)
            KF: if (brk) bus.F_break = val; else bus.F_make = val;
            KE: if (brk) bus.E_break = val; else bus.E_make = val;
            KT: if (brk) bus.T_break = val; else bus.T_make = val;
            KR: if (brk) bus.R_break = val; else bus.R_make = val;
            KW: if (brk) bus.W_break = val; else bus.W_make = val;
            KS: if (brk) bus.S_break = val; else bus.S_make = val;
            KA: if (brk) bus.A_break = val; else bus.A_make = val;
            KD: if (brk) bus.D_break = val; else bus.D_make = val;
            default: if (brk) bus.Q_break = val; else bus.Q_make = val;
        endcase
    endtask

    task automatic all_flags(input logic val);
        for (int k = 0; k <= KQ; k++) begin
            set_flag(k, 1'b0, val);
            set_flag(k, 1'b1, val);
        end
    endtask

    // Flag high across exactly one rising edge; returns on the following negedge.
    task automatic hit(input int key, input bit brk);
        set_flag(key, brk, 1'b1);
        tick(1);
        set_flag(key, brk, 1'b0);
    endtask

    task automatic do_reset();
        all_flags(1'b0);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        all_flags(1'b1);
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (bus.buttons !== 8'h00 || bus.turbo_on !== 1'b0 || bus.changed !== 1'b0) begin
                errors++;
                $display("FAIL reset_release cyc %0d: buttons=%h turbo=%b changed=%b, want 00 0 0",
                         i, bus.buttons, bus.turbo_on, bus.changed);
            end
        end
        all_flags(1'b0);
        tick(2);
    endtask

    task automatic test_press_release();
        do_reset();
        hit(KW, 1'b0);
        checks++;
        if (bus.buttons !== 8'h00) begin
            errors++;
            $display("FAIL w_latency: buttons=%h want 00", bus.buttons);
        end
        tick(1);
        checks++;
        if (bus.buttons !== 8'h10 || bus.changed !== 1'b1) begin
            errors++;
            $display("FAIL w_make: buttons=%h changed=%b want 10 1", bus.buttons, bus.changed);
        end
        tick(1);
        checks++;
        if (bus.buttons !== 8'h10 || bus.changed !== 1'b0) begin
            errors++;
            $display("FAIL w_hold: buttons=%h changed=%b want 10 0", bus.buttons, bus.changed);
        end
        hit(KW, 1'b1);
        tick(1);
        checks++;
        if (bus.buttons !== 8'h00 || bus.changed !== 1'b1) begin
            errors++;
            $display("FAIL w_break: buttons=%h changed=%b want 00 1", bus.buttons, bus.changed);
        end
        hit(KT, 1'b0);
        hit(KR, 1'b0);
        hit(KE, 1'b0);
        tick(1);
        checks++;
        if (bus.buttons !== 8'h0E) begin
            errors++;
            $display("FAIL t_r_e_map: buttons=%h want 0e", bus.buttons);
        end
    endtask

    task automatic test_socd();
        do_reset();
        hit(KW, 1'b0);
        hit(KS, 1'b0);
        tick(1);
        checks++;
        if (bus.buttons !== 8'h00) begin
            errors++;
            $display("FAIL socd_updn: buttons=%h want 00", bus.buttons);
        end
        hit(KS, 1'b1);
        tick(1);
        checks++;
        if (bus.buttons !== 8'h10) begin
            errors++;
            $display("FAIL socd_restore_up: buttons=%h want 10", bus.buttons);
        end
        hit(KA, 1'b0);
        hit(KD, 1'b0);
        tick(1);
        checks++;
        if (bus.buttons !== 8'h10) begin
            errors++;
            $display("FAIL socd_lr: buttons=%h want 10", bus.buttons);
        end
        hit(KD, 1'b1);
        tick(1);
        checks++;
        if (bus.buttons !== 8'h50) begin
            errors++;
            $display("FAIL socd_restore_l: buttons=%h want 50", bus.buttons);
        end
    endtask

    task automatic test_turbo();
        logic exp_a;
        do_reset();
        hit(KQ, 1'b0);
        checks++;
        if (bus.turbo_on !== 1'b1) begin
            errors++;
            $display("FAIL turbo_toggle_on: turbo_on=%b want 1", bus.turbo_on);
        end
        hit(KF, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            exp_a = ((i / 4) % 2 == 0);
            checks++;
            if (bus.buttons[0] !== exp_a) begin
                errors++;
                $display("FAIL turbo_wave cyc %0d: a=%b want %b", i, bus.buttons[0], exp_a);
            end
        end
        hit(KF, 1'b1);
        tick(1);
        checks++;
        if (bus.buttons !== 8'h00) begin
            errors++;
            $display("FAIL turbo_release: buttons=%h want 00", bus.buttons);
        end
        hit(KF, 1'b0);
        tick(1);
        checks++;
        if (bus.buttons[0] !== 1'b1) begin
            errors++;
            $display("FAIL turbo_phase_reset: a=%b want 1", bus.buttons[0]);
        end
        hit(KQ, 1'b1);
        checks++;
        if (bus.turbo_on !== 1'b1) begin
            errors++;
            $display("FAIL q_break_ignored: turbo_on=%b want 1", bus.turbo_on);
        end
        hit(KQ, 1'b0);
        checks++;
        if (bus.turbo_on !== 1'b0) begin
            errors++;
            $display("FAIL turbo_toggle_off: turbo_on=%b want 0", bus.turbo_on);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        do_reset();
        hit(KD, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            checks++;
            if (bus.timeout !== (i == 20)) begin
                errors++;
                $display("FAIL timeout_pulse cyc %0d: timeout=%b want %b", i, bus.timeout, (i == 20));
            end
            if (i == 20 || i == 21) begin
                checks++;
                if (bus.buttons !== ((i == 20) ? 8'h80 : 8'h00)) begin
                    errors++;
                    $display("FAIL timeout_buttons cyc %0d: buttons=%h want %h",
                             i, bus.buttons, ((i == 20) ? 8'h80 : 8'h00));
                end
            end
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (bus.timeout === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL timeout_second: pulses=%0d want 0", pulses);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_flag(KA, 1'b0, 1'b1);
        set_flag(KA, 1'b1, 1'b1);
        tick(1);
        set_flag(KA, 1'b0, 1'b0);
        set_flag(KA, 1'b1, 1'b0);
        tick(2);
        checks++;
        if (bus.buttons !== 8'h00) begin
            errors++;
            $display("FAIL break_wins: buttons=%h want 00", bus.buttons);
        end
        set_flag(KF, 1'b0, 1'b1);
        set_flag(KE, 1'b0, 1'b1);
        tick(1);
        set_flag(KF, 1'b0, 1'b0);
        set_flag(KE, 1'b0, 1'b0);
        tick(1);
        checks++;
        if (bus.buttons !== 8'h03) begin
            errors++;
            $display("FAIL multi_key: buttons=%h want 03", bus.buttons);
        end
        hit(KQ, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(1);
        checks++;
        if (bus.buttons !== 8'h00 || bus.turbo_on !== 1'b0 ||
            bus.changed !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_turbo: buttons=%h turbo=%b changed=%b timeout=%b want 00 0 0 0",
                     bus.buttons, bus.turbo_on, bus.changed, bus.timeout);
        end
        reset = 1'b1;
        tick(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        all_flags(1'b0);
        tick(2);
        test_reset();
        test_press_release();
        test_socd();
        test_turbo();
        test_timeout();
        test_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
